// File: rtl/read_stage_rr_scheduler_pkg.sv
// Shared widths and request payload type for the VRF read-stage scheduler.
package read_stage_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned VS_W_DEF    = 5;
  localparam int unsigned GROUP_W_DEF = 4;
  localparam int unsigned SRC_W_DEF   = 4;
  localparam int unsigned IDX_W_DEF   = 3;

  typedef struct packed {
    logic [VS_W_DEF-1:0]    vs;
    logic                   offset;
    logic [GROUP_W_DEF-1:0] groupIndex;
    logic [SRC_W_DEF-1:0]   readSource;
    logic [IDX_W_DEF-1:0]   instructionIndex;
  } read_req_t;

endpackage

// File: rtl/read_stage_rr_scheduler_if.sv
// Request fan-in / single read-port fan-out bundle of the read-stage scheduler.
interface read_stage_rr_scheduler_if
  import read_stage_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned VS_W    = VS_W_DEF,
  parameter int unsigned GROUP_W = GROUP_W_DEF,
  parameter int unsigned SRC_W   = SRC_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF
);
  localparam int unsigned REQ_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         io_in_valid;
  logic [NUM_REQ-1:0]         io_in_ready;
  logic [NUM_REQ*VS_W-1:0]    io_in_bits_vs;
  logic [NUM_REQ-1:0]         io_in_bits_offset;
  logic [NUM_REQ*GROUP_W-1:0] io_in_bits_groupIndex;
  logic [NUM_REQ*SRC_W-1:0]   io_in_bits_readSource;
  logic [NUM_REQ*IDX_W-1:0]   io_in_bits_instructionIndex;

  logic                       io_out_ready;
  logic                       io_out_valid;
  logic [VS_W-1:0]            io_out_bits_vs;
  logic                       io_out_bits_offset;
  logic [GROUP_W-1:0]         io_out_bits_groupIndex;
  logic [SRC_W-1:0]           io_out_bits_readSource;
  logic [IDX_W-1:0]           io_out_bits_instructionIndex;
  logic [REQ_W-1:0]           io_out_bits_requester;

  modport master (
    output io_in_valid, io_in_bits_vs, io_in_bits_offset, io_in_bits_groupIndex,
           io_in_bits_readSource, io_in_bits_instructionIndex, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_vs, io_out_bits_offset,
           io_out_bits_groupIndex, io_out_bits_readSource, io_out_bits_instructionIndex,
           io_out_bits_requester
  );

  modport slave (
    input  io_in_valid, io_in_bits_vs, io_in_bits_offset, io_in_bits_groupIndex,
           io_in_bits_readSource, io_in_bits_instructionIndex, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_vs, io_out_bits_offset,
           io_out_bits_groupIndex, io_out_bits_readSource, io_out_bits_instructionIndex,
           io_out_bits_requester
  );

endinterface

// File: rtl/read_stage_rr_scheduler_rr_pick_one.sv
// Combinational rotate-priority picker: first set valid bit at or above i_ptr, wrapping.
module rr_pick_one #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [REQ_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [REQ_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    // Walk offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!o_any && i_valid[j] && (((32'(i_ptr) + off) % NUM_REQ) == j)) begin
          o_any = 1'b1;
          o_idx = REQ_W'(j);
        end
      end
    end
    o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/read_stage_rr_scheduler.sv
// Round-robin arbiter feeding one registered VRF read slot from NUM_REQ requesters.
// Define READ_STAGE_SCHED_PERF_EN to add saturating grant/stall counters.
module read_stage_rr_scheduler
  import read_stage_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned VS_W    = VS_W_DEF,
  parameter int unsigned GROUP_W = GROUP_W_DEF,
  parameter int unsigned SRC_W   = SRC_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF
) (
  input logic clock,
  input logic reset,
  read_stage_rr_scheduler_if.slave bus
`ifdef READ_STAGE_SCHED_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0] io_perf_grant,
  output logic [15:0]           io_perf_stall
`endif
);

  localparam int unsigned REQ_W = $clog2(NUM_REQ);

  logic                r_out_valid;
  logic [VS_W-1:0]     r_vs;
  logic                r_offset;
  logic [GROUP_W-1:0]  r_group;
  logic [SRC_W-1:0]    r_src;
  logic [IDX_W-1:0]    r_instr;
  logic [REQ_W-1:0]    r_requester;
  logic [REQ_W-1:0]    r_rr_ptr;

  logic [NUM_REQ-1:0]  w_grant;
  logic [REQ_W-1:0]    w_idx;
  logic                w_any;
  logic                w_slot_free;
  logic                w_xfer;
  logic [VS_W-1:0]     w_sel_vs;
  logic                w_sel_offset;
  logic [GROUP_W-1:0]  w_sel_group;
  logic [SRC_W-1:0]    w_sel_src;
  logic [IDX_W-1:0]    w_sel_instr;

  rr_pick_one #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_valid (bus.io_in_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_slot_free     = !r_out_valid || bus.io_out_ready;
  // Ready is masked during reset so nothing is accepted into a slot that is being cleared.
  assign w_xfer          = w_any && w_slot_free && !reset;
  assign bus.io_in_ready = w_xfer ? w_grant : '0;

  always_comb begin
    w_sel_vs     = '0;
    w_sel_offset = 1'b0;
    w_sel_group  = '0;
    w_sel_src    = '0;
    w_sel_instr  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_vs     = bus.io_in_bits_vs[i*VS_W +: VS_W];
        w_sel_offset = bus.io_in_bits_offset[i];
        w_sel_group  = bus.io_in_bits_groupIndex[i*GROUP_W +: GROUP_W];
        w_sel_src    = bus.io_in_bits_readSource[i*SRC_W +: SRC_W];
        w_sel_instr  = bus.io_in_bits_instructionIndex[i*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_vs        <= '0;
      r_offset    <= 1'b0;
      r_group     <= '0;
      r_src       <= '0;
      r_instr     <= '0;
      r_requester <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_vs        <= w_sel_vs;
      r_offset    <= w_sel_offset;
      r_group     <= w_sel_group;
      r_src       <= w_sel_src;
      r_instr     <= w_sel_instr;
      r_requester <= w_idx;
      r_rr_ptr    <= (w_idx == REQ_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end else if (bus.io_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.io_out_valid                 = r_out_valid;
  assign bus.io_out_bits_vs               = r_vs;
  assign bus.io_out_bits_offset           = r_offset;
  assign bus.io_out_bits_groupIndex       = r_group;
  assign bus.io_out_bits_readSource       = r_src;
  assign bus.io_out_bits_instructionIndex = r_instr;
  assign bus.io_out_bits_requester        = r_requester;

`ifdef READ_STAGE_SCHED_PERF_EN
  logic [15:0] r_perf_grant [NUM_REQ];
  logic [15:0] r_perf_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_perf_grant[i] <= '0;
      r_perf_stall <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_xfer && w_grant[i] && (r_perf_grant[i] != 16'hFFFF)) begin
          r_perf_grant[i] <= r_perf_grant[i] + 16'd1;
        end
      end
      if (r_out_valid && !bus.io_out_ready && (r_perf_stall != 16'hFFFF)) begin
        r_perf_stall <= r_perf_stall + 16'd1;
      end
    end
  end

  always_comb begin
    io_perf_grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) io_perf_grant[i*16 +: 16] = r_perf_grant[i];
  end
  assign io_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_read_stage_rr_scheduler.sv
// Scoreboarded bench for read_stage_rr_scheduler: directed round-robin cases plus random traffic.
module tb_read_stage_rr_scheduler;
  import read_stage_pkg::*;

  localparam int unsigned N = 4;

  typedef struct {
    read_req_t   p;
    int unsigned who;
  } exp_t;

  logic clock;
  logic reset;

  read_stage_rr_scheduler_if bus ();

`ifdef READ_STAGE_SCHED_PERF_EN
  logic [N*16-1:0] perf_grant;
  logic [15:0]     perf_stall;
`endif

  read_stage_rr_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef READ_STAGE_SCHED_PERF_EN
    ,
    .io_perf_grant (perf_grant),
    .io_perf_stall (perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  exp_t        sb[$];
  read_req_t   cur [N];
  int unsigned m_ptr  = 0;
  bit          m_full = 1'b0;
  int          fix_vs = -1;

  logic [N-1:0] obs_ready;
  logic         obs_val;
  logic [1:0]   obs_req;
  logic [4:0]   obs_vs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: drive, check against the model at negedge, then advance the model.
  task automatic drive_cycle(input logic rst_v, input logic [N-1:0] valid, input logic rdy);
    bit          e_any;
    int unsigned e_idx;
    bit          e_free;
    logic [N-1:0] e_ready;
    exp_t        e;
    reset            = rst_v;
    bus.io_in_valid  = valid;
    bus.io_out_ready = rdy;
    for (int i = 0; i < N; i++) begin
      cur[i].vs               = (fix_vs >= 0) ? fix_vs[4:0] : 5'($urandom);
      cur[i].offset           = 1'($urandom);
      cur[i].groupIndex       = 4'($urandom);
      cur[i].readSource       = 4'($urandom);
      cur[i].instructionIndex = 3'($urandom);
      bus.io_in_bits_vs[i*5 +: 5]               = cur[i].vs;
      bus.io_in_bits_offset[i]                  = cur[i].offset;
      bus.io_in_bits_groupIndex[i*4 +: 4]       = cur[i].groupIndex;
      bus.io_in_bits_readSource[i*4 +: 4]       = cur[i].readSource;
      bus.io_in_bits_instructionIndex[i*3 +: 3] = cur[i].instructionIndex;
    end
    @(negedge clock);
    e_any = 1'b0;
    e_idx = 0;
    for (int off = 0; off < N; off++) begin
      if (!e_any && valid[(m_ptr + off) % N]) begin
        e_any = 1'b1;
        e_idx = (m_ptr + off) % N;
      end
    end
    e_free  = !m_full || rdy;
    e_ready = (e_any && e_free && !rst_v) ? N'(1 << e_idx) : '0;
    check_eq("in_ready", bus.io_in_ready, e_ready);
    check_eq("out_valid", bus.io_out_valid, m_full);
    if (m_full && bus.io_out_valid && sb.size() > 0) begin
      check_eq("out_vs", bus.io_out_bits_vs, sb[0].p.vs);
      check_eq("out_offset", bus.io_out_bits_offset, sb[0].p.offset);
      check_eq("out_group", bus.io_out_bits_groupIndex, sb[0].p.groupIndex);
      check_eq("out_src", bus.io_out_bits_readSource, sb[0].p.readSource);
      check_eq("out_instr", bus.io_out_bits_instructionIndex, sb[0].p.instructionIndex);
      check_eq("out_requester", bus.io_out_bits_requester, sb[0].who);
    end
    obs_ready = bus.io_in_ready;
    obs_val   = bus.io_out_valid;
    obs_req   = bus.io_out_bits_requester;
    obs_vs    = bus.io_out_bits_vs;
    @(posedge clock);
    #1;
    if (rst_v) begin
      m_full = 1'b0;
      m_ptr  = 0;
      sb.delete();
    end else begin
      if (m_full && rdy && sb.size() > 0) void'(sb.pop_front());
      if (e_any && e_free) begin
        e.p    = cur[e_idx];
        e.who  = e_idx;
        sb.push_back(e);
        m_full = 1'b1;
        m_ptr  = (e_idx + 1) % N;
      end else if (rdy) begin
        m_full = 1'b0;
      end
    end
  endtask

  logic [N-1:0] seq_exp [5];

  initial begin
    reset                           = 1'b1;
    bus.io_in_valid                 = '0;
    bus.io_out_ready                = 1'b0;
    bus.io_in_bits_vs               = '0;
    bus.io_in_bits_offset           = '0;
    bus.io_in_bits_groupIndex       = '0;
    bus.io_in_bits_readSource       = '0;
    bus.io_in_bits_instructionIndex = '0;
    repeat (2) @(posedge clock);
    #1;

    // Reset held with every requester asking: nothing accepted, outputs zero.
    drive_cycle(1'b1, 4'hF, 1'b0);
    check_eq("rst_vs", bus.io_out_bits_vs, 0);
    check_eq("rst_offset", bus.io_out_bits_offset, 0);
    check_eq("rst_group", bus.io_out_bits_groupIndex, 0);
    check_eq("rst_src", bus.io_out_bits_readSource, 0);
    check_eq("rst_instr", bus.io_out_bits_instructionIndex, 0);
    check_eq("rst_requester", bus.io_out_bits_requester, 0);

    // All four valid: grants rotate 0,1,2,3,0; requester tag trails by one cycle.
    seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
    seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, 4'hF, 1'b1);
      check_eq("rr_seq_grant", obs_ready, seq_exp[k]);
      if (k > 0) check_eq("rr_seq_req", obs_req, (k - 1) % 4);
    end
    drive_cycle(1'b0, 4'h0, 1'b1);
    check_eq("rr_seq_req_last", obs_req, 0);
    check_eq("idle_no_valid_after", bus.io_out_valid, 0);

    // Bring pointer to 2, then requesters 1 and 3: grant 3, then 1, pointer back at 2.
    drive_cycle(1'b0, 4'b0010, 1'b1);
    check_eq("ptr_setup", obs_ready, 4'b0010);
    drive_cycle(1'b0, 4'b1010, 1'b1);
    check_eq("wrap_first", obs_ready, 4'b1000);
    drive_cycle(1'b0, 4'b1010, 1'b1);
    check_eq("wrap_second", obs_ready, 4'b0010);
    drive_cycle(1'b0, 4'hF, 1'b1);
    check_eq("wrap_ptr_at2", obs_ready, 4'b0100);

    // Load vs=1A, then stall three cycles: output held, no ready, pointer unmoved.
    fix_vs = 5'h1A;
    drive_cycle(1'b0, 4'hF, 1'b1);
    check_eq("hold_load", obs_ready, 4'b1000);
    fix_vs = -1;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 4'hF, 1'b0);
      check_eq("hold_ready", obs_ready, 0);
      check_eq("hold_vs", obs_vs, 5'h1A);
    end
    drive_cycle(1'b0, 4'hF, 1'b1);
    check_eq("hold_ptr_kept", obs_ready, 4'b0001);

    // Slot full, drained and refilled by requester 2 on the same edge.
    drive_cycle(1'b0, 4'b0100, 1'b1);
    check_eq("thru_accept", obs_ready, 4'b0100);
    drive_cycle(1'b0, 4'b0000, 1'b0);
    check_eq("thru_valid", obs_val, 1);
    check_eq("thru_req", obs_req, 2);

    // Reset while full and requester 1 waiting.
    drive_cycle(1'b1, 4'b0010, 1'b0);
    check_eq("midrst_valid", bus.io_out_valid, 0);
    drive_cycle(1'b0, 4'b0011, 1'b1);
    check_eq("midrst_fav0", obs_ready, 4'b0001);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive_cycle(1'b0, N'($urandom), ($urandom_range(0, 3) != 0));
    end

`ifdef READ_STAGE_SCHED_PERF_EN
    drive_cycle(1'b1, 4'h0, 1'b0);
    for (int k = 0; k < 70000; k++) drive_cycle(1'b0, 4'b0001, 1'b1);
    check_eq("perf_grant0_sat", perf_grant[15:0], 16'hFFFF);
    check_eq("perf_grant1", perf_grant[31:16], 0);
    check_eq("perf_stall", perf_stall, 0);
`endif

    drive_cycle(1'b0, 4'h0, 1'b1);
    drive_cycle(1'b0, 4'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
